// File: rtl/aes_avl_responder.sv
// Avalon-MM register responder for the AES decrypt peripheral: key/ciphertext/result
// registers, START/DONE handshake with the external core and a busy-cycle counter.
module aes_avl_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  AVL_CS,
  input  logic                  AVL_READ,
  input  logic                  AVL_WRITE,
  input  logic [ADDR_W-1:0]     AVL_ADDR,
  input  logic [DATA_W/8-1:0]   AVL_BYTE_EN,
  input  logic [DATA_W-1:0]     AVL_WRITEDATA,
  output logic [DATA_W-1:0]     AVL_READDATA,
  output logic                  core_start,
  output logic [4*DATA_W-1:0]   core_key,
  output logic [4*DATA_W-1:0]   core_msg_en,
  input  logic                  core_valid,
  input  logic [4*DATA_W-1:0]   core_msg_de,
  output logic [DATA_W-1:0]     EXPORT_DATA
);
  // Bus handshake: a transfer happens in any cycle where AVL_CS and a strobe are high;
  // writes take effect at that edge, read data appears on AVL_READDATA one cycle later.
  localparam int                NUM_GP   = 12;
  localparam logic [ADDR_W-1:0] A_CYCLES = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] A_SPARE  = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] A_START  = ADDR_W'(14);
  localparam logic [ADDR_W-1:0] A_DONE   = ADDR_W'(15);

  // START = (state != IDLE), DONE = (state == FINISHED)
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_FINISHED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] gp_q [NUM_GP];
  logic [DATA_W-1:0] gp_d [NUM_GP];
  logic [DATA_W-1:0] spare_q, spare_d;
  logic [DATA_W-1:0] cycles_q, cycles_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_en, rd_en, start_cur, start_nxt, capture;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0]   old_v,
                                                    input logic [DATA_W-1:0]   new_v,
                                                    input logic [DATA_W/8-1:0] be);
    merge_lanes = old_v;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (be[b]) merge_lanes[8*b +: 8] = new_v[8*b +: 8];
    end
  endfunction

  always_comb begin
    wr_en     = AVL_CS & AVL_WRITE;
    rd_en     = AVL_CS & AVL_READ;
    start_cur = (state_q != ST_IDLE);
    capture   = core_valid & start_cur;
    gp_d      = gp_q;
    spare_d   = spare_q;
    start_nxt = start_cur;

    if (wr_en) begin
      if (AVL_ADDR < A_CYCLES) begin
        gp_d[AVL_ADDR] = merge_lanes(gp_q[AVL_ADDR], AVL_WRITEDATA, AVL_BYTE_EN);
      end else if (AVL_ADDR == A_SPARE) begin
        spare_d = merge_lanes(spare_q, AVL_WRITEDATA, AVL_BYTE_EN);
      end else if (AVL_ADDR == A_START && AVL_BYTE_EN[0]) begin
        start_nxt = AVL_WRITEDATA[0];
      end
    end

    // Applied after the bus write so the core result wins on a collision
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        gp_d[8+i] = core_msg_de[4*DATA_W-1-DATA_W*i -: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start_nxt) state_d = ST_BUSY;
      ST_BUSY:     if (!start_nxt) state_d = ST_IDLE;
                   else if (core_valid) state_d = ST_FINISHED;
      ST_FINISHED: if (!start_nxt) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cycles_d = cycles_q;
    if (state_q == ST_IDLE && state_d == ST_BUSY) begin
      cycles_d = '0;
    end else if (state_q == ST_BUSY && cycles_q != '1) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      if (AVL_ADDR < A_CYCLES) begin
        rdata_d = gp_q[AVL_ADDR];
      end else begin
        case (AVL_ADDR)
          A_CYCLES: rdata_d = cycles_q;
          A_SPARE:  rdata_d = spare_q;
          A_START:  rdata_d = DATA_W'(start_cur);
          A_DONE:   rdata_d = DATA_W'(state_q == ST_FINISHED);
          default:  rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= ST_IDLE;
      spare_q  <= '0;
      cycles_q <= '0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      spare_q  <= spare_d;
      cycles_q <= cycles_d;
      rdata_q  <= rdata_d;
      for (int i = 0; i < NUM_GP; i++) gp_q[i] <= gp_d[i];
    end
  end

  assign AVL_READDATA = rdata_q;
  assign core_start   = (state_q == ST_BUSY);
  assign core_key     = {gp_q[0], gp_q[1], gp_q[2], gp_q[3]};
  assign core_msg_en  = {gp_q[4], gp_q[5], gp_q[6], gp_q[7]};
  assign EXPORT_DATA  = {gp_q[0][DATA_W-1:DATA_W/2], gp_q[3][DATA_W/2-1:0]};

endmodule

// File: tb/tb_aes_avl_responder.sv
// Bench for aes_avl_responder: register-map vector table, START/DONE/capture sequences,
// async reset, then randomized traffic against a register-level reference model.
module tb_aes_avl_responder;
  logic         clk_clk = 1'b0;
  logic         reset_reset_n;
  logic         AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]   AVL_ADDR, AVL_BYTE_EN;
  logic [31:0]  AVL_WRITEDATA, AVL_READDATA, EXPORT_DATA;
  logic         core_start, core_valid;
  logic [127:0] core_key, core_msg_en, core_msg_de;

  localparam logic [127:0] MSG = 128'h00112233445566778899AABBCCDDEEFF;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  // Reference model: the software-visible register map
  logic [31:0] m_reg[16];
  bit          m_start, m_done;
  logic [31:0] m_cycles, m_rdata;

  typedef struct {
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[8];

  always #5 clk_clk = ~clk_clk;

  aes_avl_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .core_start    (core_start),
    .core_key      (core_key),
    .core_msg_en   (core_msg_en),
    .core_valid    (core_valid),
    .core_msg_de   (core_msg_de),
    .EXPORT_DATA   (EXPORT_DATA)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
    m_start  = 1'b0;
    m_done   = 1'b0;
    m_cycles = 32'h0;
    m_rdata  = 32'h0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd12:   return m_cycles;
      4'd14:   return {31'b0, m_start};
      4'd15:   return {31'b0, m_done};
      default: return m_reg[a];
    endcase
  endfunction

  // One bus/core clock cycle: drive, advance the model, clock, then compare outputs
  task automatic cycle(input bit cs, input bit rd, input bit wr, input logic [3:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       input bit valid, input logic [127:0] de);
    bit new_start, new_done;
    AVL_CS = cs; AVL_READ = rd; AVL_WRITE = wr; AVL_ADDR = addr;
    AVL_BYTE_EN = be; AVL_WRITEDATA = wd; core_valid = valid; core_msg_de = de;

    if (cs && rd) exp_q.push_back(m_read(addr));
    new_start = m_start;
    if (cs && wr) begin
      if (addr == 4'd14) begin
        if (be[0]) new_start = wd[0];
      end else if (addr != 4'd12 && addr != 4'd15) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_reg[addr][8*b +: 8] = wd[8*b +: 8];
      end
    end
    new_done = m_done;
    if (valid && m_start) begin
      m_reg[8]  = de[127:96];
      m_reg[9]  = de[95:64];
      m_reg[10] = de[63:32];
      m_reg[11] = de[31:0];
      new_done  = 1'b1;
    end
    if (!new_start) new_done = 1'b0;
    if (!m_start && new_start) m_cycles = 32'h0;
    else if (m_start && !m_done && m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 1;
    m_start = new_start;
    m_done  = new_done;

    @(posedge clk_clk);
    #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; core_valid = 1'b0;
    if (cs && rd) m_rdata = exp_q.pop_front();
    check("readdata", AVL_READDATA, m_rdata);
    check("core_start", core_start, m_start && !m_done);
    check("export_data", EXPORT_DATA, {m_reg[0][31:16], m_reg[3][15:0]});
    check("core_key", core_key, {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
    check("core_msg_en", core_msg_en, {m_reg[4], m_reg[5], m_reg[6], m_reg[7]});
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] wd);
    cycle(1'b1, 1'b0, 1'b1, addr, be, wd, 1'b0, 128'h0);
  endtask

  task automatic rd_reg(input logic [3:0] addr);
    cycle(1'b1, 1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, 128'h0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 128'h0);
  endtask

  initial begin
    int           n_busy;
    bit           r_cs, r_rd, r_wr, r_valid;
    logic [3:0]   r_addr, r_be;
    logic [31:0]  r_wd;
    logic [127:0] r_de;

    vecs[0] = '{4'd0,  4'b0101, 32'hDEADBEEF, 32'h00AD00EF};
    vecs[1] = '{4'd3,  4'b1111, 32'h12345678, 32'h12345678};
    vecs[2] = '{4'd12, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{4'd15, 4'b1111, 32'hFFFFFFFF, 32'h00000000};
    vecs[4] = '{4'd14, 4'b1110, 32'hFFFFFFFF, 32'h00000000};
    vecs[5] = '{4'd13, 4'b0011, 32'hA5A5A5A5, 32'h0000A5A5};
    vecs[6] = '{4'd9,  4'b1000, 32'h11223344, 32'h11000000};
    vecs[7] = '{4'd1,  4'b0000, 32'hFFFFFFFF, 32'h00000000};

    AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_ADDR = 4'h0;
    AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = 32'h0; core_valid = 1'b0; core_msg_de = 128'h0;
    reset_reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_clk);
    #1;
    check("reset_readdata", AVL_READDATA, 32'h0);
    check("reset_export", EXPORT_DATA, 32'h0);
    check("reset_core_start", core_start, 1'b0);
    #2 reset_reset_n = 1'b1;

    // Every address reads 0 out of reset
    for (int a = 0; a < 16; a++) begin
      rd_reg(4'(a));
      check($sformatf("reset_read_%0d", a), AVL_READDATA, 32'h0);
    end

    // Register map vectors: write then read back
    for (int i = 0; i < 8; i++) begin
      wr_reg(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      rd_reg(vecs[i].addr);
      check($sformatf("vec%0d_read", i), AVL_READDATA, vecs[i].exp_rd);
    end
    check("export_after_table", EXPORT_DATA, 32'h00AD5678);

    // START, 10 busy cycles, capture colliding with a bus write to reg9
    n_busy = 0;
    wr_reg(4'd14, 4'h1, 32'h1);
    if (core_start === 1'b1) n_busy++;
    repeat (9) begin
      idle();
      if (core_start === 1'b1) n_busy++;
    end
    cycle(1'b1, 1'b0, 1'b1, 4'd9, 4'hF, 32'hFFFFFFFF, 1'b1, MSG);
    if (core_start === 1'b1) n_busy++;
    check("core_start_high_cycles", n_busy, 10);
    check("core_start_dropped", core_start, 1'b0);
    rd_reg(4'd8);  check("capture_reg8", AVL_READDATA, 32'h00112233);
    rd_reg(4'd9);  check("capture_wins_reg9", AVL_READDATA, 32'h44556677);
    rd_reg(4'd11); check("capture_reg11", AVL_READDATA, 32'hCCDDEEFF);
    rd_reg(4'd15); check("done_set", AVL_READDATA, 32'h1);
    idle();
    idle();
    rd_reg(4'd12); check("cycles_frozen_10", AVL_READDATA, 32'd10);

    // Clear START, stray core_valid, restart
    wr_reg(4'd14, 4'h1, 32'h0);
    rd_reg(4'd15); check("done_cleared", AVL_READDATA, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ~MSG);
    rd_reg(4'd8);  check("stray_valid_ignored", AVL_READDATA, 32'h00112233);
    wr_reg(4'd14, 4'h1, 32'h1);
    rd_reg(4'd12); check("cycles_restart", AVL_READDATA, 32'h0);

    // Asynchronous reset mid-BUSY, off the clock edge
    repeat (3) idle();
    rd_reg(4'd0);
    check("pre_reset_readdata", AVL_READDATA, 32'h00AD00EF);
    #2 reset_reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_core_start", core_start, 1'b0);
    check("async_rst_readdata", AVL_READDATA, 32'h0);
    check("async_rst_export", EXPORT_DATA, 32'h0);
    @(posedge clk_clk);
    #3 reset_reset_n = 1'b1;
    rd_reg(4'd14); check("post_rst_start", AVL_READDATA, 32'h0);
    rd_reg(4'd12); check("post_rst_cycles", AVL_READDATA, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, MSG);
    rd_reg(4'd8);  check("post_rst_valid_ignored", AVL_READDATA, 32'h0);
    wr_reg(4'd12, 4'hF, 32'hFFFFFFFF);
    rd_reg(4'd12); check("cycles_read_only", AVL_READDATA, 32'h0);
    wr_reg(4'd15, 4'hF, 32'hFFFFFFFF);
    rd_reg(4'd15); check("done_read_only", AVL_READDATA, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_cs    = ($urandom_range(0, 7) != 0);
      r_rd    = $urandom_range(0, 1) != 0;
      r_wr    = $urandom_range(0, 1) != 0;
      r_addr  = 4'($urandom_range(0, 15));
      r_be    = 4'($urandom_range(0, 15));
      r_wd    = $urandom;
      r_valid = ($urandom_range(0, 9) == 0);
      r_de    = {$urandom, $urandom, $urandom, $urandom};
      cycle(r_cs, r_rd, r_wr, r_addr, r_be, r_wd, r_valid, r_de);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
